// File: rtl/penc_pkg.sv
// Shared types and sizing helpers for the round-robin priority-encoder arbiter.
package penc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int opt_of(input int len);
        return 2 ** len;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Hold counter width; a zero or one-cycle limit still needs one bit.
    function automatic int cnt_width(input int max_hold);
        return (clog2(max_hold) < 1) ? 1 : clog2(max_hold);
    endfunction

endpackage

// File: rtl/penc_min.sv
// Lowest-index priority encoder; an all-zero input encodes to 0.
module penc_min
    import penc_pkg::*;
#(
    parameter int LEN = 4,
    localparam int OPT = opt_of(LEN)
) (
    input  logic [OPT-1:0] X,
    output logic [LEN-1:0] Y
);

    // NOTE: blocking assignments in always_comb; scanning downward lets the
    // lowest set index overwrite any higher one.
    always_comb begin
        Y = '0;
        for (int i = OPT - 1; i >= 0; i--) begin
            if (X[i]) Y = LEN'(i);
        end
    end

endmodule

// File: rtl/penc_rr_arbiter.sv
// Round-robin arbiter: rotating-pointer mask in front of two lowest-index
// encoders, with a registered, held grant, release handshake and hold timeout.
module penc_rr_arbiter
    import penc_pkg::*;
#(
    parameter int LEN = 4,
    parameter int MAX_HOLD = 16,
    localparam int OPT = opt_of(LEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPT-1:0] X,
    input  logic           done,
    output logic [LEN-1:0] Y,
    output logic           valid,
    output logic           timeout
);

    localparam int CW = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t         state, state_n;
    logic [LEN-1:0] ptr, ptr_n;
    logic [LEN-1:0] y_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           timeout_n;

    logic [OPT-1:0] low_mask;
    logic [OPT-1:0] masked;
    logic [LEN-1:0] masked_y, raw_y, winner;
    logic           hold_hit, withdrawn, release_now;

    // Requesters at or above the pointer keep priority this round.
    always_comb begin
        for (int i = 0; i < OPT; i++) begin
            low_mask[i] = (i >= int'(ptr));
        end
    end

    assign masked = X & low_mask;

    penc_min #(.LEN(LEN)) u_penc_masked (
        .X (masked),
        .Y (masked_y)
    );

    penc_min #(.LEN(LEN)) u_penc_raw (
        .X (X),
        .Y (raw_y)
    );

    assign winner      = (|masked) ? masked_y : raw_y;
    assign hold_hit    = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign withdrawn   = ~X[Y];
    assign release_now = done | withdrawn | hold_hit;
    assign valid       = (state == BUSY);

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_n   = state;
        y_n       = Y;
        ptr_n     = ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (|X) begin
                    y_n     = winner;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_n   = IDLE;
                    ptr_n     = Y + LEN'(1);
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_n = hold_hit & ~done & ~withdrawn;
                end else if (cnt != '1) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state so every
    // register samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            Y       <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            Y       <= y_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_penc_rr_arbiter.sv
// Scoreboard bench for penc_rr_arbiter (LEN=2, MAX_HOLD=4): stimulus queues
// expected grants, a negedge monitor checks each grant's index, length and release.
module tb_penc_rr_arbiter;

    localparam int LEN = 2;
    localparam int OPT = 4;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [LEN-1:0] y;
        int             len;
        logic           to;
    } grant_t;

    logic           clk;
    logic           rst;
    logic [OPT-1:0] X;
    logic           done;
    logic [LEN-1:0] Y;
    logic           valid;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    grant_t exp_q[$];
    grant_t cur;
    logic   active = 1'b0;
    logic   prev_v = 1'b0;
    int     len_cnt = 0;

    penc_rr_arbiter #(.LEN(LEN), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .X       (X),
        .done    (done),
        .Y       (Y),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [LEN-1:0] y, input int len, input logic to);
        grant_t g;
        g.y   = y;
        g.len = len;
        g.to  = to;
        exp_q.push_back(g);
    endtask

    // Monitor: pops on each grant rise, checks length/timeout/Y-hold on each fall.
    always @(negedge clk) begin
        if (rst) begin
            active  = 1'b0;
            prev_v  = 1'b0;
            len_cnt = 0;
        end else begin
            if (valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", int'(Y), -1);
                end else begin
                    cur     = exp_q.pop_front();
                    active  = 1'b1;
                    len_cnt = 0;
                    check("grant_y", int'(Y), int'(cur.y));
                end
            end
            if (valid) len_cnt++;
            if (!valid && prev_v && active) begin
                check("hold_len", len_cnt, cur.len);
                check("release_timeout", int'(timeout), int'(cur.to));
                check("release_y_held", int'(Y), int'(cur.y));
                active = 1'b0;
            end else if (!valid && !prev_v) begin
                check("idle_timeout_low", int'(timeout), 0);
            end
            prev_v = valid;
        end
    end

    initial begin
        rst  = 1'b1;
        X    = '0;
        done = 1'b0;

        // 1: reset, no requests
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_valid", int'(valid), 0);
            check("rst_y", int'(Y), 0);
            check("rst_timeout", int'(timeout), 0);
        end
        step(1);

        // 2: ptr=0, X=1010 -> Y=1; done -> ptr=2 -> Y=3
        X = 4'b1010;
        expect_grant(2'd1, 1, 1'b0);
        expect_grant(2'd3, 1, 1'b0);
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;

        // 3: ptr wrapped to 0, X=0101 -> Y=0, then Y=2
        X = 4'b0101;
        expect_grant(2'd0, 1, 1'b0);
        expect_grant(2'd2, 1, 1'b0);
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;

        // 4: ptr=3, X=0001 held -> wrap to Y=0, 4-cycle timeout, regrant Y=0
        X = 4'b0001;
        expect_grant(2'd0, 4, 1'b1);
        expect_grant(2'd0, 2, 1'b0);
        step(5);
        step(2);
        X = 4'b0000;
        step(1);

        // 5a: ptr=1, X=0100 -> Y=2, withdrawn at cnt=1 -> ptr=3
        X = 4'b0100;
        expect_grant(2'd2, 2, 1'b0);
        step(2);
        X = 4'b0000;
        step(1);

        // 5b: ptr=3, X=1000 -> Y=3, done coincides with cnt=3 -> no timeout
        X = 4'b1000;
        expect_grant(2'd3, 4, 1'b0);
        step(4);
        done = 1'b1;
        step(1);
        done = 1'b0;
        X = 4'b0000;
        step(1);

        // 6: ptr=0, X=1000 -> Y=3; async reset at cnt=2
        X = 4'b1000;
        expect_grant(2'd3, 0, 1'b0);
        step(3);
        check("pre_rst_valid", int'(valid), 1);
        check("pre_rst_y", int'(Y), 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_y", int'(Y), 0);
        check("async_rst_timeout", int'(timeout), 0);
        step(1);
        rst = 1'b0;
        expect_grant(2'd3, 1, 1'b0);
        step(1);
        done = 1'b1;
        X = 4'b0000;
        step(1);
        done = 1'b0;

        for (int i = 0; i < 20 && (exp_q.size() != 0 || active); i++) step(1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_open_grant", int'(active), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
